// File: rtl/cdb_arbiter.sv
// rtl/cdb_arbiter.sv - round-robin writeback arbiter feeding the ROB/CDB result register
module cdb_arbiter #(
    parameter int FU_COUNT = 8,
    parameter int ROBID_W  = 4,
    parameter int DATA_W   = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        flush,
    input  logic [FU_COUNT-1:0]         fu_req,
    input  logic [FU_COUNT*ROBID_W-1:0] fu_robid,
    input  logic [FU_COUNT*DATA_W-1:0]  fu_wbs,
    input  logic [FU_COUNT*DATA_W-1:0]  fu_flags,
    input  logic [FU_COUNT*DATA_W-1:0]  fu_value,
    output logic [FU_COUNT-1:0]         fu_grant,
    input  logic                        out_ready,
    output logic                        rob_transmit,
    output logic [ROBID_W-1:0]          rob_id,
    output logic [DATA_W-1:0]           rob_wbs,
    output logic [DATA_W-1:0]           rob_flags,
    output logic [DATA_W-1:0]           rob_value,
    output logic                        cdb_transmit,
    output logic [3:0]                  cdb_id,
    output logic [DATA_W-1:0]           cdb_val
);

    localparam int PTR_W = (FU_COUNT > 1) ? $clog2(FU_COUNT) : 1;

    logic                  out_valid;
    logic [ROBID_W-1:0]    id_q;
    logic [DATA_W-1:0]     wbs_q;
    logic [DATA_W-1:0]     flags_q;
    logic [DATA_W-1:0]     value_q;
    logic [PTR_W-1:0]      ptr;

    logic                  accept;
    logic                  found;
    logic [PTR_W-1:0]      off;
    logic [PTR_W:0]        sum;
    logic [PTR_W-1:0]      win;
    logic [PTR_W-1:0]      next_ptr;
    logic [2*FU_COUNT-1:0] req2;
    logic [FU_COUNT-1:0]   rot;

    // Grants are suppressed while in reset so nothing is consumed from the FUs.
    assign accept = rst & (~out_valid | out_ready) & ~flush;

    // Rotate requests so bit 0 is the FU at ptr, then take the lowest set bit.
    assign req2 = {fu_req, fu_req};
    assign rot  = req2[ptr +: FU_COUNT];

    always_comb begin
        found = 1'b0;
        off   = '0;
        for (int k = FU_COUNT - 1; k >= 0; k--) begin
            if (rot[k]) begin
                found = accept;
                off   = PTR_W'(k);
            end
        end
    end

    always_comb begin
        sum = {1'b0, ptr} + {1'b0, off};
        if (sum >= (PTR_W + 1)'(FU_COUNT)) begin
            sum = sum - (PTR_W + 1)'(FU_COUNT);
        end
        win = sum[PTR_W-1:0];
    end

    assign next_ptr = (win == PTR_W'(FU_COUNT - 1)) ? '0 : win + 1'b1;
    assign fu_grant = found ? (FU_COUNT'(1) << win) : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid <= 1'b0;
            id_q      <= '0;
            wbs_q     <= '0;
            flags_q   <= '0;
            value_q   <= '0;
            ptr       <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
            id_q      <= '0;
            wbs_q     <= '0;
            flags_q   <= '0;
            value_q   <= '0;
        end else if (found) begin
            out_valid <= 1'b1;
            id_q      <= fu_robid[win*ROBID_W +: ROBID_W];
            wbs_q     <= fu_wbs[win*DATA_W +: DATA_W];
            flags_q   <= fu_flags[win*DATA_W +: DATA_W];
            value_q   <= fu_value[win*DATA_W +: DATA_W];
            ptr       <= next_ptr;
        end else if (out_ready) begin
            // Drained with nothing to replace it; fields go to 0 for the OR-bus.
            out_valid <= 1'b0;
            id_q      <= '0;
            wbs_q     <= '0;
            flags_q   <= '0;
            value_q   <= '0;
        end
    end

    assign rob_transmit = out_valid;
    assign rob_id       = id_q;
    assign rob_wbs      = wbs_q;
    assign rob_flags    = flags_q;
    assign rob_value    = value_q;
    assign cdb_transmit = out_valid & flags_q[0];
    assign cdb_id       = cdb_transmit ? wbs_q[3:0] : 4'h0;
    assign cdb_val      = cdb_transmit ? value_q : '0;

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb/tb_cdb_arbiter.sv - randomized self-checking bench for cdb_arbiter against a reference model
module tb_cdb_arbiter;

    localparam int N  = 8;
    localparam int RW = 4;
    localparam int DW = 8;

    logic            clk = 1'b0;
    logic            rst;
    logic            flush;
    logic [N-1:0]    fu_req;
    logic [N*RW-1:0] fu_robid;
    logic [N*DW-1:0] fu_wbs;
    logic [N*DW-1:0] fu_flags;
    logic [N*DW-1:0] fu_value;
    logic [N-1:0]    fu_grant;
    logic            out_ready;
    logic            rob_transmit;
    logic [RW-1:0]   rob_id;
    logic [DW-1:0]   rob_wbs;
    logic [DW-1:0]   rob_flags;
    logic [DW-1:0]   rob_value;
    logic            cdb_transmit;
    logic [3:0]      cdb_id;
    logic [DW-1:0]   cdb_val;

    cdb_arbiter #(.FU_COUNT(N), .ROBID_W(RW), .DATA_W(DW)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .fu_req(fu_req), .fu_robid(fu_robid), .fu_wbs(fu_wbs),
        .fu_flags(fu_flags), .fu_value(fu_value), .fu_grant(fu_grant),
        .out_ready(out_ready), .rob_transmit(rob_transmit), .rob_id(rob_id),
        .rob_wbs(rob_wbs), .rob_flags(rob_flags), .rob_value(rob_value),
        .cdb_transmit(cdb_transmit), .cdb_id(cdb_id), .cdb_val(cdb_val)
    );

    always #5 clk = ~clk;

    // Per-FU request state, packed onto the buses before each cycle.
    logic          req   [N];
    logic [RW-1:0] r_id  [N];
    logic [DW-1:0] r_wbs [N];
    logic [DW-1:0] r_flg [N];
    logic [DW-1:0] r_val [N];

    // Reference model: the held result and the round-robin start index.
    bit          m_valid;
    logic [RW-1:0] m_id;
    logic [DW-1:0] m_wbs, m_flg, m_val;
    int          m_ptr;
    int          last_w;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic pack();
        for (int i = 0; i < N; i++) begin
            fu_req[i]             = req[i];
            fu_robid[i*RW +: RW]  = r_id[i];
            fu_wbs[i*DW +: DW]    = r_wbs[i];
            fu_flags[i*DW +: DW]  = r_flg[i];
            fu_value[i*DW +: DW]  = r_val[i];
        end
    endtask

    task automatic model_clear();
        m_valid = 0; m_id = '0; m_wbs = '0; m_flg = '0; m_val = '0;
    endtask

    function automatic int model_win();
        if (!rst || flush || (m_valid && !out_ready)) return -1;
        for (int k = 0; k < N; k++) begin
            if (req[(m_ptr + k) % N]) return (m_ptr + k) % N;
        end
        return -1;
    endfunction

    task automatic check_outputs(input string tag);
        bit cdb_exp;
        cdb_exp = m_valid && m_flg[0];
        check({tag, ".rob_transmit"}, 32'(rob_transmit), 32'(m_valid));
        check({tag, ".rob_id"},       32'(rob_id),       32'(m_id));
        check({tag, ".rob_wbs"},      32'(rob_wbs),      32'(m_wbs));
        check({tag, ".rob_flags"},    32'(rob_flags),    32'(m_flg));
        check({tag, ".rob_value"},    32'(rob_value),    32'(m_val));
        check({tag, ".cdb_transmit"}, 32'(cdb_transmit), 32'(cdb_exp));
        check({tag, ".cdb_id"},       32'(cdb_id),       cdb_exp ? 32'(m_wbs % 16) : 32'd0);
        check({tag, ".cdb_val"},      32'(cdb_val),      cdb_exp ? 32'(m_val) : 32'd0);
    endtask

    // One clock: check the combinational grant, clock, update model, check the register.
    task automatic step(input string tag);
        int w;
        pack();
        #1;
        w = model_win();
        check({tag, ".fu_grant"}, 32'(fu_grant), (w >= 0) ? (32'd1 << w) : 32'd0);
        @(posedge clk);
        if (!rst) begin
            model_clear();
            m_ptr = 0;
        end else if (flush) begin
            model_clear();
        end else if (w >= 0) begin
            m_valid = 1; m_id = r_id[w]; m_wbs = r_wbs[w]; m_flg = r_flg[w]; m_val = r_val[w];
            m_ptr = (w + 1) % N;
            req[w] = 0;
        end else if (out_ready) begin
            model_clear();
        end
        last_w = w;
        #1;
        check_outputs(tag);
    endtask

    task automatic set_req(input int i, input logic [RW-1:0] id, input logic [DW-1:0] wbs,
                           input logic [DW-1:0] flg, input logic [DW-1:0] val);
        req[i] = 1; r_id[i] = id; r_wbs[i] = wbs; r_flg[i] = flg; r_val[i] = val;
    endtask

    task automatic clear_reqs();
        for (int i = 0; i < N; i++) req[i] = 0;
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin
            req[i] = 1; r_id[i] = RW'(i + 8); r_wbs[i] = '0; r_flg[i] = '0; r_val[i] = '0;
        end
        rst = 1'b0; flush = 1'b0; out_ready = 1'b1;
        model_clear(); m_ptr = 0; last_w = -1;
        pack();
        #2;
        check("reset.fu_grant", 32'(fu_grant), 32'd0);
        check_outputs("reset");
        @(posedge clk); #1;
        rst = 1'b1;

        // All FUs requesting: grants sweep 0..7 then wrap to 0.
        for (int k = 0; k < N + 1; k++) begin
            for (int i = 0; i < N; i++) req[i] = 1;
            step("sweep");
            check("sweep.order", 32'(last_w), 32'(k % N));
        end

        // Backpressure: held result stays put, FU2 waits for out_ready.
        clear_reqs();
        set_req(2, 4'h5, 8'h21, 8'h01, 8'hc3);
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step("stall");
            check("stall.nogrant", 32'(last_w + 1), 32'd0);
        end
        out_ready = 1'b1;
        step("unstall");
        check("unstall.win", 32'(last_w), 32'd2);

        // Lone requester keeps winning with the pointer parked just past it.
        clear_reqs();
        for (int k = 0; k < 4; k++) begin
            set_req(5, RW'(k), 8'(k), 8'h00, 8'(k * 3));
            step("lone5");
            check("lone5.win", 32'(last_w), 32'd5);
        end

        // Flush with a held result and FU1 waiting.
        clear_reqs();
        set_req(1, 4'h9, 8'h36, 8'h01, 8'h5a);
        flush = 1'b1;
        step("flush");
        check("flush.nogrant", 32'(last_w + 1), 32'd0);
        flush = 1'b0;
        step("postflush");
        check("postflush.win", 32'(last_w), 32'd1);

        // CDB gating on flags bit 0.
        clear_reqs();
        set_req(3, 4'h3, 8'h47, 8'h00, 8'h99);
        step("cdb_off");
        check("cdb_off.cdb_transmit", 32'(cdb_transmit), 32'd0);
        set_req(3, 4'h4, 8'h47, 8'h01, 8'h99);
        step("cdb_on");
        check("cdb_on.cdb_id", 32'(cdb_id), 32'h7);
        check("cdb_on.cdb_val", 32'(cdb_val), 32'h99);

        // Asynchronous reset mid-transfer, then lowest-index requester wins.
        clear_reqs();
        set_req(4, 4'hb, 8'h12, 8'h01, 8'h44);
        out_ready = 1'b0;
        step("prereset");
        #2;
        rst = 1'b0;
        #1;
        model_clear();
        m_ptr = 0;
        check("async_rst.rob_transmit", 32'(rob_transmit), 32'd0);
        check("async_rst.fu_grant", 32'(fu_grant), 32'd0);
        check_outputs("async_rst");
        @(posedge clk); #1;
        rst = 1'b1;
        out_ready = 1'b1;
        clear_reqs();
        set_req(6, 4'h1, 8'h61, 8'h01, 8'h66);
        set_req(2, 4'h2, 8'h22, 8'h01, 8'h23);
        step("post_rst");
        check("post_rst.win", 32'(last_w), 32'd2);

        // Randomized traffic: requests held until granted, occasional drops.
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < N; i++) begin
                if (req[i]) begin
                    if ($urandom_range(15) == 0) req[i] = 0;
                end else if ($urandom_range(2) == 0) begin
                    set_req(i, RW'($urandom), DW'($urandom), DW'($urandom), DW'($urandom));
                end
            end
            out_ready = ($urandom_range(3) != 0);
            flush     = ($urandom_range(15) == 0);
            step("rand");
        end
        flush = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
